// File: rtl/btn_event_decoder_pkg.sv
// Shared state encodings and board-clock defaults for the button event decoder.
package btn_event_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btnState_t;

  localparam int DEFAULT_CNT_W         = 16;
  localparam int DEFAULT_HOLD_CYCLES   = 40000;
  localparam int DEFAULT_REPEAT_CYCLES = 10000;

endpackage

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle press, release, long-press
// and auto-repeat events, plus a registered "held" level.
module btn_event_decoder
  import btn_event_decoder_pkg::*;
#(
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic debounce_btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btnState_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_repeat;
  logic              r_held;

  btnState_t         w_nextState;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              w_press;
  logic              w_release;
  logic              w_long;
  logic              w_repeat;

  // Next-state, counter and event decode; release always wins over a threshold hit.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (debounce_btn) begin
          w_nextState = ST_PRESSED;
          w_nextCnt   = '0;
          w_press     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!debounce_btn) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
          w_release   = 1'b1;
        end else if (r_cnt == HOLD_LAST) begin
          w_nextState = ST_LONG;
          w_nextCnt   = '0;
          w_long      = 1'b1;
          w_repeat    = 1'b1;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!debounce_btn) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
          w_release   = 1'b1;
        end else if (r_cnt == REPEAT_LAST) begin
          w_nextCnt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset silently returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= (w_nextState != ST_IDLE);
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_press    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed self-checking bench for btn_event_decoder with HOLD=8, REPEAT=4.
module tb_btn_event_decoder;

  logic clk;
  logic rst;
  logic debounce_btn;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;

  int testsRun;
  int testsFailed;

  btn_event_decoder #(
    .CNT_W(16),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .debounce_btn(debounce_btn),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then wait one full cycle so the
  // rising edge in between samples them.
  task automatic applyStimulus(input logic rstIn, input logic btnIn);
    rst          = rstIn;
    debounce_btn = btnIn;
    @(negedge clk);
  endtask

  // Compare {press, release, long, repeat, held} against the expected vector.
  task automatic checkOutput(input string tag, input int stepNo, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {press_pulse, release_pulse, long_press, repeat_pulse, held};
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s step %0d: observed %b expected %b (press,release,long,repeat,held)",
             tag, stepNo, observed, expected);
    end
  endtask

  task automatic stepCheck(input string tag, input int stepNo, input logic rstIn,
                           input logic btnIn, input logic [4:0] expected);
    applyStimulus(rstIn, btnIn);
    checkOutput(tag, stepNo, expected);
  endtask

  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_PRS  = 5'b10001;
  localparam logic [4:0] E_REL  = 5'b01000;
  localparam logic [4:0] E_HELD = 5'b00001;
  localparam logic [4:0] E_LONG = 5'b00111;
  localparam logic [4:0] E_REP  = 5'b00011;

  // Linear sequence of directed scenarios.
  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b1;
    debounce_btn = 1'b1;

    // Reset with the button held: outputs stay low, press right after reset drops.
    for (int i = 0; i < 3; i++) stepCheck("rstHeld", i, 1'b1, 1'b1, E_NONE);
    stepCheck("rstHeld", 3, 1'b0, 1'b1, E_PRS);
    stepCheck("rstHeld", 4, 1'b0, 1'b0, E_REL);
    stepCheck("rstHeld", 5, 1'b0, 1'b0, E_NONE);

    // Short press of five cycles.
    stepCheck("short", 0, 1'b0, 1'b1, E_PRS);
    for (int i = 1; i < 5; i++) stepCheck("short", i, 1'b0, 1'b1, E_HELD);
    stepCheck("short", 5, 1'b0, 1'b0, E_REL);
    stepCheck("short", 6, 1'b0, 1'b0, E_NONE);

    // Release exactly on the edge where the hold threshold would fire.
    stepCheck("relAtThr", 0, 1'b0, 1'b1, E_PRS);
    for (int i = 1; i < 8; i++) stepCheck("relAtThr", i, 1'b0, 1'b1, E_HELD);
    stepCheck("relAtThr", 8, 1'b0, 1'b0, E_REL);
    stepCheck("relAtThr", 9, 1'b0, 1'b0, E_NONE);

    // Long hold of 20 cycles; release collides with a would-be repeat at e20.
    stepCheck("long", 0, 1'b0, 1'b1, E_PRS);
    for (int i = 1; i < 20; i++) begin
      if (i == 8)
        stepCheck("long", i, 1'b0, 1'b1, E_LONG);
      else if (i == 12 || i == 16)
        stepCheck("long", i, 1'b0, 1'b1, E_REP);
      else
        stepCheck("long", i, 1'b0, 1'b1, E_HELD);
    end
    stepCheck("long", 20, 1'b0, 1'b0, E_REL);
    stepCheck("long", 21, 1'b0, 1'b0, E_NONE);

    // Reset while in the long-press state: no release, fresh press afterwards.
    stepCheck("rstLong", 0, 1'b0, 1'b1, E_PRS);
    for (int i = 1; i < 12; i++)
      stepCheck("rstLong", i, 1'b0, 1'b1, (i == 8) ? E_LONG : E_HELD);
    stepCheck("rstLong", 12, 1'b1, 1'b1, E_NONE);
    stepCheck("rstLong", 13, 1'b0, 1'b1, E_PRS);
    stepCheck("rstLong", 14, 1'b0, 1'b1, E_HELD);
    stepCheck("rstLong", 15, 1'b0, 1'b0, E_REL);
    stepCheck("rstLong", 16, 1'b0, 1'b0, E_NONE);

    // Back-to-back presses separated by a single low cycle.
    stepCheck("b2b", 0, 1'b0, 1'b1, E_PRS);
    stepCheck("b2b", 1, 1'b0, 1'b1, E_HELD);
    stepCheck("b2b", 2, 1'b0, 1'b1, E_HELD);
    stepCheck("b2b", 3, 1'b0, 1'b0, E_REL);
    stepCheck("b2b", 4, 1'b0, 1'b1, E_PRS);
    stepCheck("b2b", 5, 1'b0, 1'b1, E_HELD);
    stepCheck("b2b", 6, 1'b0, 1'b1, E_HELD);
    stepCheck("b2b", 7, 1'b0, 1'b0, E_REL);
    stepCheck("b2b", 8, 1'b0, 1'b0, E_NONE);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
